simple_fixed_2_result_pipe: RTL and testbench

//   Result pipeline for the Simple Fixed 2 (rotate/shift) unit. Captures the unit's same-cycle
//   RT result, delays it LATENCY cycles to the register-file write port, and exposes every
//   in-flight result to the register-fetch stage as a forwarding source. Supports partial

---
 rtl/simple_fixed_2_result_pipe_pkg.sv | 22 ++
 rtl/simple_fixed_2_result_pipe_if.sv | 28 ++
 rtl/simple_fixed_2_result_pipe_fwd_select.sv | 27 ++
 rtl/simple_fixed_2_result_pipe.sv | 62 ++++++
 tb/tb_simple_fixed_2_result_pipe.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/simple_fixed_2_result_pipe_pkg.sv
// Shared result-pipe definitions for the SPU execution units: data/address widths
// and the per-stage in-flight result entry.
package spu_pkg;

  localparam int unsigned WIDTH  = 128;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned NUM_Q  = 3;

  typedef struct packed {
    logic              valid;
    logic              reg_wr;
    logic [0:ADDR_W-1] addr;
    logic [0:WIDTH-1]  data;
  } spu_result_entry_t;

  // An entry can source a forward only if it is live and actually writes RT.
  function automatic logic entry_writes(input spu_result_entry_t e,
                                        input logic [0:ADDR_W-1] addr);
    return e.valid && e.reg_wr && (e.addr == addr);
  endfunction

endpackage

// File: rtl/simple_fixed_2_result_pipe_if.sv
// Issue / forwarding / writeback bundle between the Simple Fixed 2 unit, the
// register-fetch stage and the register file.
interface simple_fixed_2_result_pipe_if;
  import spu_pkg::*;

  logic                            issue_valid;
  logic                            issue_reg_wr;
  logic [0:ADDR_W-1]               issue_rt_addr;
  logic [0:WIDTH-1]                issue_result;
  logic                            flush;
  logic [0:NUM_Q-1][0:ADDR_W-1]    q_addr;
  logic [0:NUM_Q-1]                q_hit;
  logic [0:NUM_Q-1][0:WIDTH-1]     q_data;
  logic                            wb_valid;
  logic [0:ADDR_W-1]               wb_rt_addr;
  logic [0:WIDTH-1]                wb_data;

  modport master (
    output issue_valid, issue_reg_wr, issue_rt_addr, issue_result, flush, q_addr,
    input  q_hit, q_data, wb_valid, wb_rt_addr, wb_data
  );

  modport slave (
    input  issue_valid, issue_reg_wr, issue_rt_addr, issue_result, flush, q_addr,
    output q_hit, q_data, wb_valid, wb_rt_addr, wb_data
  );

endinterface

// File: rtl/simple_fixed_2_result_pipe_fwd_select.sv
// Forwarding priority mux for one register-fetch query: youngest live writer wins,
// stages being killed by a same-cycle flush are ignored.
module spu_fwd_select
  import spu_pkg::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned KILL_DEPTH = 2
) (
  input  spu_result_entry_t [1:LATENCY] stage,
  input  logic                          flush,
  input  logic [0:ADDR_W-1]             q_addr,
  output logic                          hit,
  output logic [0:WIDTH-1]              data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned k = 1; k <= LATENCY; k++) begin
      if (!hit && entry_writes(stage[k], q_addr) && !(flush && (k <= KILL_DEPTH))) begin
        hit  = 1'b1;
        data = stage[k].data;
      end
    end
  end

endmodule

// File: rtl/simple_fixed_2_result_pipe.sv
// Simple Fixed 2 result pipeline: delays the unit's RT result to writeback and
// exposes every in-flight result as a forwarding source, with partial flush.
module simple_fixed_2_result_pipe
  import spu_pkg::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned KILL_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  simple_fixed_2_result_pipe_if.slave  pipe_if
);

  spu_result_entry_t [1:LATENCY] stage;

  logic             fwd_hit  [NUM_Q];
  logic [0:WIDTH-1] fwd_data [NUM_Q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage <= '0;
    end else begin
      stage[1].valid  <= pipe_if.issue_valid & ~pipe_if.flush;
      stage[1].reg_wr <= pipe_if.issue_reg_wr;
      stage[1].addr   <= pipe_if.issue_rt_addr;
      stage[1].data   <= pipe_if.issue_result;
      // Entries leaving stages 1..KILL_DEPTH on a flush edge arrive invalid.
      for (int unsigned k = 2; k <= LATENCY; k++) begin
        stage[k] <= stage[k-1];
        if (pipe_if.flush && ((k - 1) <= KILL_DEPTH))
          stage[k].valid <= 1'b0;
      end
    end
  end

  assign pipe_if.wb_valid   = stage[LATENCY].valid & stage[LATENCY].reg_wr;
  assign pipe_if.wb_rt_addr = stage[LATENCY].addr;
  assign pipe_if.wb_data    = stage[LATENCY].data;

  for (genvar i = 0; i < NUM_Q; i++) begin : g_fwd
    spu_fwd_select #(
      .LATENCY    (LATENCY),
      .KILL_DEPTH (KILL_DEPTH)
    ) u_fwd_select (
      .stage  (stage),
      .flush  (pipe_if.flush),
      .q_addr (pipe_if.q_addr[i]),
      .hit    (fwd_hit[i]),
      .data   (fwd_data[i])
    );
  end

  always_comb begin
    pipe_if.q_hit  = '0;
    pipe_if.q_data = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      pipe_if.q_hit[i]  = fwd_hit[i];
      pipe_if.q_data[i] = fwd_data[i];
    end
  end

endmodule

// File: tb/tb_simple_fixed_2_result_pipe.sv
// Self-checking bench for simple_fixed_2_result_pipe: writeback scoreboard queue plus
// an issue-history list used to predict forwarding each cycle.
module tb_simple_fixed_2_result_pipe;
  import spu_pkg::*;

  localparam int LAT = 4;
  localparam int KD  = 2;

  typedef struct {
    bit                alive;
    bit                reg_wr;
    logic [0:ADDR_W-1] addr;
    logic [0:WIDTH-1]  data;
    int                icyc;
  } hist_t;

  typedef struct {
    logic [0:ADDR_W-1] addr;
    logic [0:WIDTH-1]  data;
    int                icyc;
  } wb_t;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  hist_t hist[$];
  wb_t   wbq[$];

  simple_fixed_2_result_pipe_if bus ();

  simple_fixed_2_result_pipe #(
    .LATENCY    (LAT),
    .KILL_DEPTH (KD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pipe_if (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, check outputs at the falling edge, advance the model.
  task automatic run_cycle(input bit v, input bit wr, input logic [0:ADDR_W-1] a,
                           input logic [0:WIDTH-1] d, input bit fl,
                           input logic [0:ADDR_W-1] q0, input logic [0:ADDR_W-1] q1,
                           input logic [0:ADDR_W-1] q2);
    logic [0:ADDR_W-1] qa [3];
    qa[0] = q0; qa[1] = q1; qa[2] = q2;
    bus.issue_valid   = v;
    bus.issue_reg_wr  = wr;
    bus.issue_rt_addr = a;
    bus.issue_result  = d;
    bus.flush         = fl;
    for (int p = 0; p < 3; p++) bus.q_addr[p] = qa[p];
    @(negedge clk);
    if (wbq.size() > 0 && wbq[0].icyc + LAT == cyc) begin
      check_val("wb_valid", {127'b0, bus.wb_valid}, 128'd1);
      check_val("wb_rt_addr", {121'b0, bus.wb_rt_addr}, {121'b0, wbq[0].addr});
      check_val("wb_data", bus.wb_data, wbq[0].data);
      void'(wbq.pop_front());
    end else begin
      check_val("wb_valid", {127'b0, bus.wb_valid}, 128'd0);
    end
    for (int p = 0; p < 3; p++) begin
      bit               ehit = 1'b0;
      int               best = -1;
      logic [0:WIDTH-1] edata = '0;
      foreach (hist[i]) begin
        int age = cyc - hist[i].icyc;
        if (hist[i].alive && hist[i].reg_wr && hist[i].addr == qa[p] &&
            age >= 1 && age <= LAT && !(fl && age <= KD) && hist[i].icyc > best) begin
          best  = hist[i].icyc;
          ehit  = 1'b1;
          edata = hist[i].data;
        end
      end
      check_val($sformatf("q_hit%0d", p), {127'b0, bus.q_hit[p]}, {127'b0, ehit});
      check_val($sformatf("q_data%0d", p), bus.q_data[p], edata);
    end
    @(posedge clk);
    if (fl) begin
      foreach (hist[i])
        if (cyc - hist[i].icyc >= 1 && cyc - hist[i].icyc <= KD) hist[i].alive = 1'b0;
      while (wbq.size() > 0 && wbq[$].icyc >= cyc - KD) void'(wbq.pop_back());
    end
    if (v) hist.push_back('{alive: !fl, reg_wr: wr, addr: a, data: d, icyc: cyc});
    if (v && !fl && wr) wbq.push_back('{addr: a, data: d, icyc: cyc});
    while (hist.size() > 0 && (cyc + 1 - hist[0].icyc) > LAT) void'(hist.pop_front());
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic [0:ADDR_W-1] q0,
                      input logic [0:ADDR_W-1] q1, input logic [0:ADDR_W-1] q2);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, '0, '0, 1'b0, q0, q1, q2);
  endtask

  initial begin
    logic [0:WIDTH-1] ones_pat = {32{4'h1}};
    logic [0:WIDTH-1] pat_a    = {4{32'hAAAA_5555}};
    logic [0:WIDTH-1] pat_b    = {4{32'h0BAD_F00D}};
    logic [0:WIDTH-1] rnd;

    reset_n           = 1'b0;
    bus.issue_valid   = 1'b0;
    bus.issue_reg_wr  = 1'b0;
    bus.issue_rt_addr = '0;
    bus.issue_result  = '0;
    bus.flush         = 1'b0;
    bus.q_addr        = '0;
    #2;
    check_val("rst_wb_valid", {127'b0, bus.wb_valid}, 128'd0);
    check_val("rst_wb_addr", {121'b0, bus.wb_rt_addr}, 128'd0);
    check_val("rst_wb_data", bus.wb_data, 128'd0);
    check_val("rst_q_hit", {125'b0, bus.q_hit}, 128'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Single writer r5: writeback exactly LAT cycles later.
    run_cycle(1'b1, 1'b1, 7'd5, ones_pat, 1'b0, 7'd5, 7'd0, 7'd0);
    idle(6, 7'd5, 7'd5, 7'd1);

    // Two writers to r9: youngest forwarded, both written back in order.
    run_cycle(1'b1, 1'b1, 7'd9, pat_a, 1'b0, 7'd9, 7'd0, 7'd0);
    run_cycle(1'b1, 1'b1, 7'd9, pat_b, 1'b0, 7'd9, 7'd9, 7'd0);
    idle(6, 7'd9, 7'd2, 7'd9);

    // Non-writing instruction to r3: never forwards, never writes back.
    run_cycle(1'b1, 1'b0, 7'd3, pat_a, 1'b0, 7'd3, 7'd3, 7'd3);
    idle(5, 7'd3, 7'd0, 7'd3);

    // r1..r4 then a flush carrying r6: r1/r2 survive, r3/r4/r6 are killed.
    for (int i = 1; i <= 4; i++)
      run_cycle(1'b1, 1'b1, 7'(i), {4{32'(i * 32'h0101_0101)}}, 1'b0, 7'(i), 7'd1, 7'd4);
    run_cycle(1'b1, 1'b1, 7'd6, pat_b, 1'b1, 7'd4, 7'd2, 7'd3);
    idle(6, 7'd6, 7'd2, 7'd4);

    // Back-to-back random traffic over a small address window.
    for (int i = 0; i < 20; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      run_cycle(1'b1, $urandom_range(0, 7) != 0, 7'($urandom_range(0, 7)), rnd,
                $urandom_range(0, 9) == 0, 7'($urandom_range(0, 7)),
                7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)));
    end
    idle(6, 7'd0, 7'd1, 7'd2);

    // Asynchronous reset with two entries in flight.
    run_cycle(1'b1, 1'b1, 7'd10, pat_a, 1'b0, 7'd10, 7'd11, 7'd0);
    run_cycle(1'b1, 1'b1, 7'd11, pat_b, 1'b0, 7'd10, 7'd11, 7'd0);
    bus.issue_valid = 1'b0;
    bus.q_addr[0]   = 7'd10;
    bus.q_addr[1]   = 7'd11;
    #1 reset_n = 1'b0;
    #1;
    check_val("arst_wb_valid", {127'b0, bus.wb_valid}, 128'd0);
    check_val("arst_q_hit0", {127'b0, bus.q_hit[0]}, 128'd0);
    check_val("arst_q_hit1", {127'b0, bus.q_hit[1]}, 128'd0);
    check_val("arst_q_data1", bus.q_data[1], 128'd0);
    check_val("arst_wb_addr", {121'b0, bus.wb_rt_addr}, 128'd0);
    check_val("arst_wb_data", bus.wb_data, 128'd0);
    hist.delete();
    wbq.delete();
    @(posedge clk);
    cyc++;
    #1 reset_n = 1'b1;
    idle(6, 7'd10, 7'd11, 7'd0);

    // First issue after reset behaves normally.
    run_cycle(1'b1, 1'b1, 7'd127, pat_b, 1'b0, 7'd127, 7'd0, 7'd0);
    idle(6, 7'd127, 7'd0, 7'd127);

    check_val("wbq_drained", 128'(wbq.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
